// File: rtl/nn_sched_pkg.sv
// Shared types for the layer scheduler: FSM state encoding and a width helper.
// Latency: n/a (package). Backpressure: n/a.
// Contents: state_t enumeration, clog2_min1() for index widths that stay >= 1 bit.
package nn_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_MAC_REQ,
    S_MAC_NEXT,
    S_BIAS,
    S_ACT,
    S_WRITE,
    S_DONE
  } state_t;

  // $clog2 of max(v,2), so a single-entry range still gets a 1-bit index.
  function automatic int clog2_min1(input int v);
    return (v < 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/nn_index_counter.sv
// Nested input/neuron counters plus the running weight address for the scheduler.
// Latency: all outputs registered; updates take effect the cycle after a control strobe.
// Backpressure: none; the FSM only strobes inc_* when the datapath has acknowledged.
// Ports: i_clr zeroes everything; i_inc_in steps the input; i_inc_neuron steps the neuron
//        and wraps the input; o_last_in / o_last_neuron flag terminal counts.
module nn_index_counter #(
  parameter int N_IN  = 2,
  parameter int N_OUT = 2,
  parameter int IW    = 1,
  parameter int NW    = 1,
  parameter int WW    = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_clr,
  input  logic          i_inc_in,
  input  logic          i_inc_neuron,
  output logic [IW-1:0] o_in_idx,
  output logic [NW-1:0] o_neuron,
  output logic [WW-1:0] o_w_addr,
  output logic          o_last_in,
  output logic          o_last_neuron
);

  logic [IW-1:0] r_in_idx;
  logic [NW-1:0] r_neuron;
  logic [WW-1:0] r_w_addr;

  // w_addr = neuron*N_IN + in_idx is kept as a running count: the step out of the
  // last input of neuron n lands exactly on the first weight of neuron n+1.
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_in_idx <= '0;
      r_neuron <= '0;
      r_w_addr <= '0;
    end else if (i_inc_neuron) begin
      r_in_idx <= '0;
      r_neuron <= r_neuron + NW'(1);
      r_w_addr <= r_w_addr + WW'(1);
    end else if (i_inc_in) begin
      r_in_idx <= r_in_idx + IW'(1);
      r_w_addr <= r_w_addr + WW'(1);
    end
  end

  assign o_in_idx      = r_in_idx;
  assign o_neuron      = r_neuron;
  assign o_w_addr      = r_w_addr;
  assign o_last_in     = (r_in_idx == IW'(N_IN - 1));
  assign o_last_neuron = (r_neuron == NW'(N_OUT - 1));

endmodule

// File: rtl/nn_layer_scheduler.sv
// Sequences one shared MAC/bias/activation datapath over every (neuron, input) pair of a layer.
// Latency: N_OUT*(2*N_IN+3)+1 cycles start->done with zero-wait acks; +1 per ack wait cycle.
// Backpressure: mac_req/bias_req hold until their ack; acks outside their wait state are ignored.
// Ports: start/abort/busy/done to the network controller; mac_*/bias_*/act_en/acc_clr to the
//        datapath; out_we/out_idx to the output register file. Outputs decode registered state only.
module nn_layer_scheduler
  import nn_sched_pkg::*;
#(
  parameter int N_IN  = 2,
  parameter int N_OUT = 2,
  parameter int IW    = clog2_min1(N_IN),
  parameter int NW    = clog2_min1(N_OUT),
  parameter int WW    = clog2_min1(N_IN * N_OUT)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  output logic          busy,
  output logic          done,
  output logic          acc_clr,
  output logic          mac_req,
  input  logic          mac_ack,
  output logic [IW-1:0] in_idx,
  output logic [WW-1:0] w_addr,
  output logic          bias_req,
  input  logic          bias_ack,
  output logic [NW-1:0] b_addr,
  output logic          act_en,
  output logic          out_we,
  output logic [NW-1:0] out_idx
);

  state_t        r_state;
  state_t        w_next;
  logic          w_clr;
  logic          w_inc_in;
  logic          w_inc_neuron;
  logic          w_last_in;
  logic          w_last_neuron;
  logic [NW-1:0] w_neuron;

  nn_index_counter #(
    .N_IN (N_IN),
    .N_OUT(N_OUT),
    .IW   (IW),
    .NW   (NW),
    .WW   (WW)
  ) u_idx (
    .clk          (clk),
    .rst          (rst),
    .i_clr        (w_clr),
    .i_inc_in     (w_inc_in),
    .i_inc_neuron (w_inc_neuron),
    .o_in_idx     (in_idx),
    .o_neuron     (w_neuron),
    .o_w_addr     (w_addr),
    .o_last_in    (w_last_in),
    .o_last_neuron(w_last_neuron)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next       = r_state;
    w_clr        = 1'b0;
    w_inc_in     = 1'b0;
    w_inc_neuron = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_clr = 1'b1;
        // abort wins over a coincident start
        if (start && !abort) w_next = S_CLEAR;
      end
      S_CLEAR:    w_next = S_MAC_REQ;
      S_MAC_REQ: begin
        if (mac_ack) w_next = w_last_in ? S_BIAS : S_MAC_NEXT;
      end
      S_MAC_NEXT: begin
        w_inc_in = 1'b1;
        w_next   = S_MAC_REQ;
      end
      S_BIAS: begin
        if (bias_ack) w_next = S_ACT;
      end
      S_ACT:      w_next = S_WRITE;
      S_WRITE: begin
        if (w_last_neuron) begin
          w_next = S_DONE;
        end else begin
          w_inc_neuron = 1'b1;
          w_next       = S_CLEAR;
        end
      end
      S_DONE: begin
        w_clr  = 1'b1;
        w_next = S_IDLE;
      end
      default:    w_next = S_IDLE;
    endcase
    if (abort && (r_state != S_IDLE)) begin
      w_next       = S_IDLE;
      w_clr        = 1'b1;
      w_inc_in     = 1'b0;
      w_inc_neuron = 1'b0;
    end
  end

  assign busy     = (r_state != S_IDLE);
  assign done     = (r_state == S_DONE);
  assign acc_clr  = (r_state == S_CLEAR);
  assign mac_req  = (r_state == S_MAC_REQ);
  assign bias_req = (r_state == S_BIAS);
  assign act_en   = (r_state == S_ACT);
  assign out_we   = (r_state == S_WRITE);
  assign b_addr   = w_neuron;
  assign out_idx  = w_neuron;

endmodule

// File: doc/nn_layer_scheduler.md
# nn_layer_scheduler

Sequencer that time-multiplexes one shared MAC/bias/activation datapath across all neurons of a fully connected fixed-point layer. It steps through every (neuron, input) pair, drives weight/input/bias addresses and one-cycle control strobes, waits on the datapath's request/acknowledge handshakes, and writes each activated result to the layer output register file. It sits between the network-level controller (start/done) and a single layer's MAC, bias-add and activation units.

## Interface
Parameters:
- `N_IN`, default 2: inputs per neuron; must be ≥1.
- `N_OUT`, default 2: neurons in the layer; must be ≥1.
- `IW`, default `$clog2(max(N_IN,2))`: width of the input index.
- `NW`, default `$clog2(max(N_OUT,2))`: width of the neuron index.
- `WW`, default `$clog2(max(N_IN*N_OUT,2))`: width of the weight address.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: reset, synchronous, active-high.
- `start`, in, 1: begin one layer pass; sampled only in IDLE.
- `abort`, in, 1: synchronous cancel; lower priority than `rst`.
- `busy`, out, 1: high in every state except IDLE.
- `done`, out, 1: one-cycle pulse at the end of a completed pass.
- `acc_clr`, out, 1: clear accumulator (one cycle per neuron).
- `mac_req`, out, 1: MAC operation request.
- `mac_ack`, in, 1: MAC completed the operation.
- `in_idx`, out, IW: input select for the current MAC.
- `w_addr`, out, WW: weight address, equal to `neuron*N_IN + in_idx`.
- `bias_req`, out, 1: bias-add request.
- `bias_ack`, in, 1: bias add completed.
- `b_addr`, out, NW: bias address, equal to the current neuron.
- `act_en`, out, 1: activation strobe (one cycle).
- `out_we`, out, 1: output register write enable (one cycle).
- `out_idx`, out, NW: output register index, equal to the current neuron.

## Operation
- States: IDLE, CLEAR, MAC_REQ, MAC_NEXT, BIAS, ACT, WRITE, DONE.
- IDLE:
  - On `start`, go to CLEAR.
  - Neuron index and input index are set to 0.
- CLEAR: `acc_clr`=1, then go to MAC_REQ.
- MAC_REQ:
  - `mac_req`=1 and holds until `mac_ack` is sampled high. `in_idx` and `w_addr` stay stable throughout.
  - On ack with `in_idx`<N_IN-1, go to MAC_NEXT.
  - On ack with `in_idx`=N_IN-1, go to BIAS.
- MAC_NEXT: `mac_req`=0 for exactly one cycle, `in_idx` increments, then go to MAC_REQ.
- BIAS: `bias_req`=1 until `bias_ack`, then go to ACT.
- ACT: `act_en`=1, then go to WRITE.
- WRITE:
  - `out_we`=1.
  - If neuron = N_OUT-1, go to DONE.
  - Otherwise increment the neuron index, set `in_idx` to 0, and go to CLEAR.
- DONE: `done`=1, then go to IDLE.
- Acks are honoured only in their own wait state. A stray `mac_ack` or `bias_ack` in any other state is ignored.
- `start` while busy is ignored, with no queueing.
- `abort` in any non-IDLE state:
  - Next state is IDLE, with all strobes and requests 0.
  - No `done`, no `out_we`.
  - Indices are set to 0.
- `abort` and `start` together in IDLE: stay IDLE.
- `rst`:
  - State goes to IDLE.
  - All outputs are 0: `busy`, `done`, `acc_clr`, `mac_req`, `bias_req`, `act_en`, `out_we`, `in_idx`, `w_addr`, `b_addr`, `out_idx`.
  - This also applies mid-pass.
- All outputs are registered or decoded from registered state only. There are no combinational paths from `mac_ack` or `bias_ack` to any output.

## Timing
- Zero-wait datapath (ack in the same cycle as the request):
  - Each neuron takes 2·N_IN+3 cycles.
  - `done` is high in cycle c0+N_OUT·(2·N_IN+3)+1, where c0 is the cycle `start` is sampled.
  - Default parameters: `done` at c0+15, `busy` high from c0+1 through c0+15.
- Each cycle of ack delay adds one cycle to the pass. `mac_req` and `bias_req` never drop before their ack.
- `out_we` and `out_idx` are valid in the same cycle. `act_en` always precedes `out_we` by exactly 1 cycle.
- Back-to-back passes: `start` in the cycle after `done` (IDLE) begins a new pass with no bubble.

## Structure
- Package `nn_sched_pkg` holds:
  - the state enumeration;
  - the width helper `clog2_min1`.
- Sub-module `nn_index_counter` holds the nested input and neuron counters:
  - terminal-count flags `last_in` and `last_neuron`;
  - `inc_in`, `inc_neuron` and `clr` controls;
  - the `w_addr` multiply-add, done as a registered accumulate: +1 per input, carried across neurons.
- The FSM lives in the top module.

## Test plan
- Default parameters, `start` at c0, zero-wait acks -> `w_addr` sequence 0,1,2,3; `out_we` at c7 and c14 with `out_idx` 0 then 1; `done` at c15; exactly 2 `acc_clr` pulses.
- `mac_ack` delayed 3 cycles on every request -> `mac_req` held with a stable `w_addr`; `done` at c0+15+4·3=c27.
- `abort` during neuron 1's BIAS wait -> IDLE next cycle; no `done`; only one `out_we` was ever seen; a new `start` restarts at `w_addr`=0.
- `rst` asserted in MAC_REQ -> all outputs 0 the next cycle; `start` afterwards behaves like a fresh pass.
- Spurious `mac_ack` in IDLE and in BIAS, and `start` pulsed while busy -> no state change, no extra strobes, pass timing unchanged.
- N_IN=1, N_OUT=3 -> MAC_NEXT never entered; 5 cycles per neuron; `done` at c0+16.
